// File: rtl/cascade_time_counter_pkg.sv
// Shared constants for the cascaded modulo time counter.
// Direction/mode encodings and the default HH:MM:SS geometry.
package cascade_time_counter_pkg;

    localparam logic CNT_UP       = 1'b1;
    localparam logic CNT_DOWN     = 1'b0;
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam int DEF_N_STAGES = 3;
    localparam int DEF_CW       = 6;
    localparam logic [DEF_N_STAGES*DEF_CW-1:0] DEF_MODS =
        {6'd24, 6'd60, 6'd60};

endpackage

// File: rtl/cascade_time_counter_if.sv
// Control/status bundle of the cascaded time counter.
// master drives en/up_down/mode/load/load_val/hold; slave returns count/stage_tc/carry_out/done.
interface cascade_time_counter_if #(
    parameter int N_STAGES = 3,
    parameter int CW       = 6
);
    logic                   en;
    logic                   up_down;
    logic                   mode;
    logic                   load;
    logic [N_STAGES*CW-1:0] load_val;
    logic                   hold;
    logic [N_STAGES*CW-1:0] count;
    logic [N_STAGES-1:0]    stage_tc;
    logic                   carry_out;
    logic                   done;

    modport master (
        output en, up_down, mode, load, load_val, hold,
        input  count, stage_tc, carry_out, done
    );

    modport slave (
        input  en, up_down, mode, load, load_val, hold,
        output count, stage_tc, carry_out, done
    );
endinterface

// File: rtl/cascade_time_counter_stage.sv
// One modulo up/down stage: steps on ci, loads a clamped preset on load.
// Ports: clk, rst_a_n, ci (step), up_down, load, load_val, q (value), tc (terminal).
module mod_stage
    import cascade_time_counter_pkg::*;
#(
    parameter int CW  = 6,
    parameter int MOD = 60
) (
    input  logic          clk,
    input  logic          rst_a_n,
    input  logic          ci,
    input  logic          up_down,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] q,
    output logic          tc
);
    localparam logic [CW-1:0] MAX = CW'(MOD - 1);

    logic [CW-1:0] q_d;
    logic [CW-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            // Out-of-range presets saturate to the top of the range.
            q_d = (load_val > MAX) ? MAX : load_val;
        end else if (ci) begin
            if (up_down == CNT_UP) begin
                q_d = (q_q == MAX) ? '0 : q_q + CW'(1);
            end else begin
                q_d = (q_q == '0) ? MAX : q_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign tc = (up_down == CNT_UP) ? (q_q == MAX) : (q_q == '0);

endmodule

// File: rtl/cascade_time_counter.sv
// Cascaded modulo up/down counter (default HH:MM:SS) with preset, hold and one-shot.
// Ports: clk, rst_a_n (async, active-low), bus (slave: controls in, count/flags out).
module cascade_time_counter
    import cascade_time_counter_pkg::*;
#(
    parameter int                     N_STAGES = DEF_N_STAGES,
    parameter int                     CW       = DEF_CW,
    parameter logic [N_STAGES*CW-1:0] MODS     = DEF_MODS
) (
    input  logic                  clk,
    input  logic                  rst_a_n,
    cascade_time_counter_if.slave bus
);
    logic [N_STAGES-1:0] tc;
    logic [N_STAGES-1:0] ci;
    logic                all_tc;
    logic                step;
    logic                step_go;
    logic                acc;
    logic                done_d;
    logic                done_q;
    logic                carry_d;
    logic                carry_q;

    assign all_tc = &tc;
    assign step   = bus.en & ~bus.hold & ~done_q;
    // One-shot at terminal freezes the chain instead of wrapping.
    assign step_go = step & ~(bus.mode & all_tc) & ~bus.load;

    // Ripple enable: stage k steps only if every lower stage is at terminal.
    always_comb begin
        ci  = '0;
        acc = step_go;
        for (int k = 0; k < N_STAGES; k++) begin
            ci[k] = acc;
            acc   = acc & tc[k];
        end
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        localparam int M = int'(MODS[k*CW +: CW]);
        mod_stage #(
            .CW  (CW),
            .MOD (M)
        ) u_stage (
            .clk      (clk),
            .rst_a_n  (rst_a_n),
            .ci       (ci[k]),
            .up_down  (bus.up_down),
            .load     (bus.load),
            .load_val (bus.load_val[k*CW +: CW]),
            .q        (bus.count[k*CW +: CW]),
            .tc       (tc[k])
        );
    end

    always_comb begin
        done_d  = done_q;
        carry_d = 1'b0;
        if (bus.load) begin
            done_d = 1'b0;
        end else if (bus.hold) begin
            done_d = done_q;
        end else if (bus.mode == MODE_WRAP) begin
            done_d  = 1'b0;
            carry_d = step & all_tc;
        end else if (step & all_tc) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            done_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            done_q  <= done_d;
            carry_q <= carry_d;
        end
    end

    assign bus.stage_tc  = tc;
    assign bus.done      = done_q;
    assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_cascade_time_counter.sv
// Randomised and directed bench for cascade_time_counter (24/60/60).
// The reference model keeps the time as a single seconds-of-day integer.
module tb_cascade_time_counter;

    localparam int DAY = 86400;

    logic clk;
    logic rst_a_n;

    cascade_time_counter_if #(.N_STAGES(3), .CW(6)) bus ();

    cascade_time_counter dut (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    int m_tot;
    bit m_done;
    bit m_carry;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] hms(input int h, input int m,
                                        input int s);
        logic [17:0] v;
        v = {6'(h), 6'(m), 6'(s)};
        return v;
    endfunction

    function automatic logic [17:0] pack_tot(input int t);
        return hms(t / 3600, (t / 60) % 60, t % 60);
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [2:0] exp_tc(input int t, input bit up);
        logic [2:0] r;
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        if (up) r = {h == 23, m == 59, s == 59};
        else    r = {h == 0,  m == 0,  s == 0};
        return r;
    endfunction

    // Model of one clock edge from the current inputs.
    task automatic model_edge();
        bit st;
        bit term;
        int h, m, s;
        st   = bus.en && !bus.hold && !m_done;
        term = bus.up_down ? (m_tot == DAY - 1) : (m_tot == 0);
        if (bus.load) begin
            s = min_i(int'(bus.load_val[5:0]), 59);
            m = min_i(int'(bus.load_val[11:6]), 59);
            h = min_i(int'(bus.load_val[17:12]), 23);
            m_tot   = h * 3600 + m * 60 + s;
            m_done  = 1'b0;
            m_carry = 1'b0;
        end else if (bus.hold) begin
            m_carry = 1'b0;
        end else begin
            m_carry = 1'b0;
            if (!bus.mode) m_done = 1'b0;
            if (st) begin
                if (bus.mode && term) begin
                    m_done = 1'b1;
                end else begin
                    m_carry = !bus.mode && term;
                    m_tot = bus.up_down ? (m_tot + 1) % DAY
                                        : (m_tot + DAY - 1) % DAY;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(bus.count), 32'(pack_tot(m_tot)));
        chk({tag, ".tc"}, 32'(bus.stage_tc), 32'(exp_tc(m_tot, bus.up_down)));
        chk({tag, ".carry"}, 32'(bus.carry_out), 32'(m_carry));
        chk({tag, ".done"}, 32'(bus.done), 32'(m_done));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.hold = 1'b0;
    endtask

    task automatic do_load(input logic [17:0] v, input string tag);
        bus.load     = 1'b1;
        bus.load_val = v;
        cyc(tag);
        bus.load = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_tot   = 0;
        m_done  = 0;
        m_carry = 0;
        rst_a_n = 1'b0;
        bus.en       = 1'b0;
        bus.up_down  = 1'b1;
        bus.mode     = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.hold     = 1'b0;
        #12;
        check_all("rst0");
        @(negedge clk);
        rst_a_n = 1'b1;

        // Async reset mid-count
        bus.en = 1'b1;
        repeat (5) cyc("pre_rst");
        #3;
        rst_a_n = 1'b0;
        m_tot = 0; m_done = 0; m_carry = 0;
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_a_n = 1'b1;
        bus.en = 1'b0;

        // Up wrap with carry pulse
        bus.mode = 1'b0;
        bus.up_down = 1'b1;
        do_load(hms(23, 59, 59), "wrap_ld");
        bus.en = 1'b1;
        cyc("wrap");
        bus.en = 1'b0;
        cyc("wrap_after");

        // Down borrow
        bus.up_down = 1'b0;
        do_load(hms(1, 0, 0), "brw_ld");
        bus.en = 1'b1;
        cyc("borrow");
        bus.en = 1'b0;
        cyc("borrow_after");

        // One-shot down to zero
        bus.mode = 1'b1;
        do_load(hms(0, 0, 2), "os_ld");
        for (int i = 0; i < 4; i++) begin
            bus.en = 1'b1;
            cyc("oneshot");
            bus.en = 1'b0;
            cyc("oneshot_gap");
        end
        do_load(hms(0, 0, 2), "os_reld");

        // Load clamping and load-beats-tick
        bus.mode = 1'b0;
        bus.up_down = 1'b1;
        do_load(hms(25, 61, 63), "clamp");
        bus.en = 1'b1;
        do_load(hms(0, 0, 10), "ld_en");
        bus.en = 1'b0;
        cyc("ld_en_after");

        // Hold, then direction change between ticks
        do_load(hms(0, 0, 30), "hold_ld");
        bus.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.en = 1'b1;
            cyc("hold");
        end
        bus.hold = 1'b0;
        bus.en = 1'b0;
        bus.up_down = 1'b1;
        cyc("dir_idle");
        bus.en = 1'b1;
        cyc("dir_up");
        bus.en = 1'b0;
        bus.up_down = 1'b0;
        cyc("dir_idle2");
        bus.en = 1'b1;
        cyc("dir_dn");
        idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.en      = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) bus.up_down = ~bus.up_down;
            if ($urandom_range(0, 19) == 0) bus.mode = ~bus.mode;
            bus.hold    = 1'($urandom_range(0, 9) == 0);
            bus.load    = 1'($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0: bus.load_val = hms(23, 59, 58);
                1: bus.load_val = hms(0, 0, 1);
                2: bus.load_val = hms(0, 59, 59);
                default: bus.load_val = 18'($urandom);
            endcase
            cyc("rand");
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
